// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - two-write/two-read register file with per-register pending bits
module reg_file_mp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter bit BYPASS     = 1'b1,
    parameter bit ZERO_REG   = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WRITE1,
    input  logic [ADDR_WIDTH-1:0] INADDRESS1,
    input  logic [DATA_WIDTH-1:0] IN1,
    input  logic                  WRITE2,
    input  logic [ADDR_WIDTH-1:0] INADDRESS2,
    input  logic [DATA_WIDTH-1:0] IN2,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2,
    input  logic                  RESERVE,
    input  logic [ADDR_WIDTH-1:0] RESADDRESS,
    output logic                  OUT1PEND,
    output logic                  OUT2PEND,
    output logic [ADDR_WIDTH:0]   BUSYCOUNT
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      pend_q, pend_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;

    // Port 2 is applied after port 1 so it wins on an address collision;
    // reserve is applied after the write-clear so it survives a same-cycle write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
        pend_d = pend_q;
        if (WRITE1) begin
            regs_d[INADDRESS1] = IN1;
            pend_d[INADDRESS1] = 1'b0;
        end
        if (WRITE2) begin
            regs_d[INADDRESS2] = IN2;
            pend_d[INADDRESS2] = 1'b0;
        end
        if (RESERVE) pend_d[RESADDRESS] = 1'b1;
        if (ZERO_REG) begin
            regs_d[0] = '0;
            pend_d[0] = 1'b0;
        end
        count_d = '0;
        for (int i = 0; i < DEPTH; i++)
            count_d = count_d + {{ADDR_WIDTH{1'b0}}, pend_d[i]};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            pend_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        OUT1     = regs_q[OUT1ADDRESS];
        OUT2     = regs_q[OUT2ADDRESS];
        OUT1PEND = pend_q[OUT1ADDRESS];
        OUT2PEND = pend_q[OUT2ADDRESS];
        if (BYPASS) begin
            if (WRITE1 && INADDRESS1 == OUT1ADDRESS) begin
                OUT1     = IN1;
                OUT1PEND = RESERVE && RESADDRESS == OUT1ADDRESS;
            end
            if (WRITE2 && INADDRESS2 == OUT1ADDRESS) begin
                OUT1     = IN2;
                OUT1PEND = RESERVE && RESADDRESS == OUT1ADDRESS;
            end
            if (WRITE1 && INADDRESS1 == OUT2ADDRESS) begin
                OUT2     = IN1;
                OUT2PEND = RESERVE && RESADDRESS == OUT2ADDRESS;
            end
            if (WRITE2 && INADDRESS2 == OUT2ADDRESS) begin
                OUT2     = IN2;
                OUT2PEND = RESERVE && RESADDRESS == OUT2ADDRESS;
            end
        end
        if (ZERO_REG && OUT1ADDRESS == '0) begin
            OUT1     = '0;
            OUT1PEND = 1'b0;
        end
        if (ZERO_REG && OUT2ADDRESS == '0) begin
            OUT2     = '0;
            OUT2PEND = 1'b0;
        end
    end

    assign BUSYCOUNT = count_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed bench for reg_file_mp in three parameterisations
module tb_reg_file_mp;
    logic       clk = 1'b0;
    logic       rst, w1, w2, res;
    logic [2:0] a1, a2, ra1, ra2, resa;
    logic [7:0] d1, d2;

    // u_a: bypass on, u_b: bypass off, u_z: bypass on with hardwired zero register
    logic [7:0] a_o1, a_o2, b_o1, b_o2, z_o1, z_o2;
    logic       a_p1, a_p2, b_p1, b_p2, z_p1, z_p2;
    logic [3:0] a_bc, b_bc, z_bc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1'b1), .ZERO_REG(1'b0)) u_a (
        .CLK(clk), .RESET(rst), .WRITE1(w1), .INADDRESS1(a1), .IN1(d1),
        .WRITE2(w2), .INADDRESS2(a2), .IN2(d2), .OUT1ADDRESS(ra1), .OUT2ADDRESS(ra2),
        .OUT1(a_o1), .OUT2(a_o2), .RESERVE(res), .RESADDRESS(resa),
        .OUT1PEND(a_p1), .OUT2PEND(a_p2), .BUSYCOUNT(a_bc));
    reg_file_mp #(.BYPASS(1'b0), .ZERO_REG(1'b0)) u_b (
        .CLK(clk), .RESET(rst), .WRITE1(w1), .INADDRESS1(a1), .IN1(d1),
        .WRITE2(w2), .INADDRESS2(a2), .IN2(d2), .OUT1ADDRESS(ra1), .OUT2ADDRESS(ra2),
        .OUT1(b_o1), .OUT2(b_o2), .RESERVE(res), .RESADDRESS(resa),
        .OUT1PEND(b_p1), .OUT2PEND(b_p2), .BUSYCOUNT(b_bc));
    reg_file_mp #(.BYPASS(1'b1), .ZERO_REG(1'b1)) u_z (
        .CLK(clk), .RESET(rst), .WRITE1(w1), .INADDRESS1(a1), .IN1(d1),
        .WRITE2(w2), .INADDRESS2(a2), .IN2(d2), .OUT1ADDRESS(ra1), .OUT2ADDRESS(ra2),
        .OUT1(z_o1), .OUT2(z_o2), .RESERVE(res), .RESADDRESS(resa),
        .OUT1PEND(z_p1), .OUT2PEND(z_p2), .BUSYCOUNT(z_bc));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w1 = 1'b0; w2 = 1'b0; res = 1'b0;
    endtask

    initial begin
        rst = 1'b1; idle();
        a1 = '0; a2 = '0; d1 = '0; d2 = '0; ra1 = '0; ra2 = '0; resa = '0;
        tick();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            ra1 = 3'(i); ra2 = 3'(7 - i);
            #1;
            check("reset_out1", {24'd0, a_o1}, 32'h00);
            check("reset_out2", {24'd0, a_o2}, 32'h00);
            check("reset_pend", {30'd0, a_p1, a_p2}, 32'h0);
        end
        check("reset_busy", {28'd0, a_bc}, 32'd0);

        // same-address double write: port 2 wins
        w1 = 1'b1; a1 = 3'd3; d1 = 8'h5A;
        w2 = 1'b1; a2 = 3'd3; d2 = 8'hC3;
        tick(); idle();
        ra1 = 3'd3; #1;
        check("prio_a", {24'd0, a_o1}, 32'hC3);
        check("prio_b", {24'd0, b_o1}, 32'hC3);

        // forwarding versus stored-only read
        w1 = 1'b1; a1 = 3'd5; d1 = 8'h7E; ra1 = 3'd5; #1;
        check("bypass_a", {24'd0, a_o1}, 32'h7E);
        check("nobypass_b", {24'd0, b_o1}, 32'h00);
        tick(); idle(); #1;
        check("nobypass_b_after", {24'd0, b_o1}, 32'h7E);

        w1 = 1'b1; a1 = 3'd4; d1 = 8'h22;
        w2 = 1'b1; a2 = 3'd4; d2 = 8'h33; ra2 = 3'd4; #1;
        check("bypass_prio", {24'd0, a_o2}, 32'h33);
        check("nobypass_old", {24'd0, b_o2}, 32'h00);
        tick(); idle();

        // reserve counting, no double count
        res = 1'b1; resa = 3'd2; tick();
        check("busy_1", {28'd0, a_bc}, 32'd1);
        resa = 3'd4; tick();
        check("busy_2", {28'd0, a_bc}, 32'd2);
        resa = 3'd2; tick();
        check("busy_dup", {28'd0, a_bc}, 32'd2);
        idle();
        w1 = 1'b1; a1 = 3'd2; d1 = 8'h11; ra1 = 3'd2; #1;
        check("pend_bypass_a", {31'd0, a_p1}, 32'd0);
        check("pend_nobypass_b", {31'd0, b_p1}, 32'd1);
        tick(); idle(); #1;
        check("busy_clear", {28'd0, a_bc}, 32'd1);
        check("pend_clear", {31'd0, a_p1}, 32'd0);
        check("data_2", {24'd0, a_o1}, 32'h11);
        ra2 = 3'd4; #1;
        check("pend_4", {31'd0, a_p2}, 32'd1);

        // write and reserve same address
        w1 = 1'b1; a1 = 3'd6; d1 = 8'h99; res = 1'b1; resa = 3'd6; ra1 = 3'd6; #1;
        check("wr_res_fwd_data", {24'd0, a_o1}, 32'h99);
        check("wr_res_fwd_pend", {31'd0, a_p1}, 32'd1);
        tick(); idle(); #1;
        check("wr_res_data", {24'd0, a_o1}, 32'h99);
        check("wr_res_pend", {31'd0, a_p1}, 32'd1);
        check("wr_res_busy", {28'd0, a_bc}, 32'd2);

        // reset between edges has no effect until the edge, and beats a write
        rst = 1'b1; #1;
        check("rst_mid_busy", {28'd0, a_bc}, 32'd2);
        check("rst_mid_data", {24'd0, a_o1}, 32'h99);
        w2 = 1'b1; a2 = 3'd1; d2 = 8'hFF;
        tick(); rst = 1'b0; idle();
        ra1 = 3'd1; #1;
        check("rst_wr_data", {24'd0, a_o1}, 32'h00);
        check("rst_busy", {28'd0, a_bc}, 32'd0);
        ra1 = 3'd6; #1;
        check("rst_reg6", {24'd0, a_o1}, 32'h00);

        // hardwired zero register
        w1 = 1'b1; a1 = 3'd0; d1 = 8'hAB; res = 1'b1; resa = 3'd0; ra1 = 3'd0; #1;
        check("zero_fwd_data", {24'd0, z_o1}, 32'h00);
        check("zero_fwd_pend", {31'd0, z_p1}, 32'd0);
        tick(); idle(); #1;
        check("zero_data", {24'd0, z_o1}, 32'h00);
        check("zero_pend", {31'd0, z_p1}, 32'd0);
        check("zero_busy", {28'd0, z_bc}, 32'd0);
        check("nonzero_data", {24'd0, a_o1}, 32'hAB);
        check("nonzero_busy", {28'd0, a_bc}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the register width in bits.
REQ-002 Parameter ADDR_WIDTH, default 3, SHALL set the address width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when 1.
REQ-004 Parameter ZERO_REG, default 0, SHALL make register 0 read-only zero when 1.
REQ-005 CLK  input  1  single clock; all state changes on its rising edge.
REQ-006 RESET  input  1  reset; synchronous, active-high.
REQ-007 WRITE1  input  1  write enable, port 1.
REQ-008 INADDRESS1  input  ADDR_WIDTH  write address, port 1.
REQ-009 IN1  input  DATA_WIDTH  write data, port 1.
REQ-010 WRITE2, INADDRESS2, IN2  input  1 / ADDR_WIDTH / DATA_WIDTH  write port 2, same meaning as port 1.
REQ-011 OUT1ADDRESS, OUT2ADDRESS  input  ADDR_WIDTH  read addresses.
REQ-012 OUT1, OUT2  output  DATA_WIDTH  read data.
REQ-013 RESERVE  input  1  mark register RESADDRESS pending.
REQ-014 RESADDRESS  input  ADDR_WIDTH  address to reserve.
REQ-015 OUT1PEND, OUT2PEND  output  1  pending flag of register at OUT1ADDRESS / OUT2ADDRESS.
REQ-016 BUSYCOUNT  output  ADDR_WIDTH+1  number of pending registers.

Function
REQ-017 Storage SHALL be DEPTH registers of DATA_WIDTH bits plus one pending bit per register.
REQ-018 Reads SHALL be combinational, zero-cycle, from current register contents.
REQ-019 On a rising CLK edge with RESET low, WRITEn high SHALL load INn into register INADDRESSn.
REQ-020 Both ports writing the same address in one cycle SHALL store IN2 (port 2 has priority).
REQ-021 A write SHALL clear the pending bit of its target register on the same edge.
REQ-022 RESERVE high SHALL set the pending bit of RESADDRESS on the edge.
REQ-023 Write and RESERVE to the same address in one cycle SHALL store the data and leave pending = 1 (reserve applied after clear).
REQ-024 RESERVE of an already-pending register SHALL leave state unchanged (no double count).
REQ-025 When BYPASS = 1 and a read address equals an asserted write address, OUTn SHALL return that write data in the same cycle (IN2 if both ports match); OUTnPEND SHALL read 0 unless the same address is also being reserved.
REQ-026 When BYPASS = 0, reads SHALL return stored contents only; new data visible the cycle after the write.
REQ-027 When ZERO_REG = 1, register 0 SHALL always read 0, writes and RESERVE to it SHALL be ignored, and its pending bit SHALL stay 0 (including under bypass).
REQ-028 BUSYCOUNT SHALL equal the population count of pending bits, registered, updated on the same edge as the bits; range 0..DEPTH without wrap.
REQ-029 Out-of-range behaviour is impossible by construction; all addresses SHALL be valid.

Reset
REQ-030 RESET high at a rising edge SHALL clear all registers to 0, all pending bits to 0 and BUSYCOUNT to 0, overriding any write or RESERVE that cycle.
REQ-031 After the reset edge, OUT1/OUT2 SHALL read 0 and OUT1PEND/OUT2PEND 0 for all addresses (bypassed writes still forward combinationally when RESET is low).
REQ-032 RESET asserted between edges SHALL have no effect until the next rising edge.

Verification
REQ-033 Reset then read all 8 addresses -> OUT1 = OUT2 = 0x00, BUSYCOUNT = 0.
REQ-034 WRITE1 addr 3 = 0x5A, WRITE2 addr 3 = 0xC3 same edge; next cycle read 3 -> 0xC3.
REQ-035 BYPASS = 1: WRITE1 addr 5 = 0x7E, OUT1ADDRESS = 5 same cycle -> OUT1 = 0x7E before the edge; BYPASS = 0 -> old value until after the edge.
REQ-036 RESERVE addr 2, then addr 4, then addr 2 again -> BUSYCOUNT 1, 2, 2; WRITE1 addr 2 = 0x11 -> BUSYCOUNT 1, OUT1PEND(2) = 0.
REQ-037 Same cycle WRITE1 addr 6 = 0x99 and RESERVE addr 6 -> register 6 = 0x99, pending 1; RESET asserted with WRITE2 addr 1 = 0xFF -> register 1 = 0x00, BUSYCOUNT 0.
REQ-038 ZERO_REG = 1: WRITE1 addr 0 = 0xAB plus RESERVE addr 0 -> OUT1(0) = 0x00, OUT1PEND = 0, BUSYCOUNT unchanged.
